// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM controller with byte enables and a clear sequencer (RAM_WRITE_THROUGH_EN adds write echo).
// Latency: read data registered, ReadValid one cycle after accept; a clear takes exactly DEPTH cycles.
// Backpressure: ReqReady drops while clearing and in any cycle Clear is sampled high; requester holds ReqValid.
module ram_ctrl #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 14,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    MemWrite,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH/8-1:0] ByteEnable,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic                    Clear,
    output logic                    ReadValid,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    Busy
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] old_word;

    assign Busy     = (state == ST_CLEAR);
    assign ReqReady = (state == ST_READY) && !Clear;
    assign accept   = ReqValid && ReqReady;
    assign old_word = mem[Address];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // Counter parks on the last address so it never wraps; re-entry reloads it.
                    if (clr_cnt == LAST_ADDR) state <= ST_READY;
                    else                      clr_cnt <= clr_cnt + 1'b1;
                end
                default: begin
                    if (Clear) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Array has no reset; the clear sequencer is the only way to zero it.
    always_ff @(posedge Clock) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && MemWrite) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (ByteEnable[i]) mem[Address][8*i +: 8] <= WriteData[8*i +: 8];
            end
        end
    end

`ifdef RAM_WRITE_THROUGH_EN
    logic [DATA_WIDTH-1:0] merged_word;

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (ByteEnable[i]) merged_word[8*i +: 8] = WriteData[8*i +: 8];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ReadValid <= 1'b0;
            ReadData  <= '0;
        end else begin
            ReadValid <= accept;
            if (accept) ReadData <= MemWrite ? merged_word : old_word;
        end
    end
`else
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ReadValid <= 1'b0;
            ReadData  <= '0;
        end else begin
            ReadValid <= accept && !MemWrite;
            if (accept && !MemWrite) ReadData <= old_word;
        end
    end
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: directed table, corner sequences and random traffic against a word-array model.
module tb_ram_ctrl;

`ifdef RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        Clock, Reset, ReqValid, ReqReady, MemWrite, Clear, ReadValid, Busy;
  logic [3:0]  Address, ByteEnable;
  logic [31:0] WriteData, ReadData;

  ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .MemWrite(MemWrite), .Address(Address), .ByteEnable(ByteEnable),
    .WriteData(WriteData), .Clear(Clear), .ReadValid(ReadValid),
    .ReadData(ReadData), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array, remaining clear cycles, expected read port.
  logic [31:0] model_mem [16];
  int          clear_left;
  logic        exp_rv;
  logic [31:0] exp_rd;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input logic v, input logic w, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic clr);
    logic rdy, acc;
    ReqValid = v; MemWrite = w; Address = a; ByteEnable = be; WriteData = wd; Clear = clr;
    #1;
    rdy = (clear_left == 0) && !clr;
    chk1("ReqReady", ReqReady, rdy);
    chk1("Busy", Busy, clear_left != 0);
    acc = v && rdy;
    exp_rv = 1'b0;
    if (clear_left > 0) begin
      clear_left--;
    end else if (clr) begin
      clear_left = 16;
      zero_model();
    end else if (acc) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[a][8*i +: 8] = wd[8*i +: 8];
        if (WT) begin
          exp_rv = 1'b1;
          exp_rd = model_mem[a];
        end
      end else begin
        exp_rv = 1'b1;
        exp_rd = model_mem[a];
      end
    end
    @(posedge Clock); #1;
    chk1("ReadValid", ReadValid, exp_rv);
    chk32("ReadData", ReadData, exp_rd);
  endtask

  task automatic apply_reset();
    Reset = 1'b1; ReqValid = 1'b0; Clear = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk1("rst_ReadValid", ReadValid, 1'b0);
    chk32("rst_ReadData", ReadData, 32'h0);
    chk1("rst_Busy", Busy, 1'b1);
    chk1("rst_ReqReady", ReqReady, 1'b0);
    Reset = 1'b0;
    clear_left = 16;
    exp_rv = 1'b0;
    exp_rd = 32'h0;
    zero_model();
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;  // read result, or merged word echoed by a write
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic exp_v;
    logic [3:0] ra, rbe;

    vec[0]  = '{1'b1, 4'd5, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF};
    vec[1]  = '{1'b1, 4'd5, 4'b0001, 32'h000000AA, 32'hDEADBEAA};
    vec[2]  = '{1'b0, 4'd5, 4'b0000, 32'h0,        32'hDEADBEAA};
    vec[3]  = '{1'b1, 4'd3, 4'b1111, 32'h12345678, 32'h12345678};
    vec[4]  = '{1'b0, 4'd3, 4'b0000, 32'h0,        32'h12345678};
    vec[5]  = '{1'b0, 4'd0, 4'b0000, 32'h0,        32'h00000000};
    vec[6]  = '{1'b0, 4'd3, 4'b0000, 32'h0,        32'h12345678};
    vec[7]  = '{1'b0, 4'd5, 4'b0000, 32'h0,        32'hDEADBEAA};
    vec[8]  = '{1'b0, 4'd7, 4'b0000, 32'h0,        32'h00000000};
    vec[9]  = '{1'b1, 4'd9, 4'b1111, 32'hAABBCCDD, 32'hAABBCCDD};
    vec[10] = '{1'b1, 4'd9, 4'b1100, 32'h11223344, 32'h1122CCDD};
    vec[11] = '{1'b0, 4'd9, 4'b0000, 32'h0,        32'h1122CCDD};
    vec[12] = '{1'b1, 4'd9, 4'b0000, 32'hFFFFFFFF, 32'h1122CCDD};
    vec[13] = '{1'b0, 4'd9, 4'b0000, 32'h0,        32'h1122CCDD};

    Reset = 1'b0; ReqValid = 1'b0; MemWrite = 1'b0; Address = 4'd0;
    ByteEnable = 4'd0; WriteData = 32'h0; Clear = 1'b0;
    clear_left = 0; exp_rv = 1'b0; exp_rd = 32'h0;
    zero_model();
    #2;
    apply_reset();

    // Clear after reset must last exactly 16 cycles.
    n = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!Busy) break;
      n++;
      @(posedge Clock); #1;
    end
    chk32("clear_len_after_reset", n, 32'd16);
    chk1("ready_after_clear", ReqReady, 1'b1);
    @(posedge Clock); #1;
    clear_left = 0;

    for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 4'(k), 4'h0, 32'h0, 1'b0);

    for (int k = 0; k < NV; k++) begin
      cycle(1'b1, vec[k].w, vec[k].a, vec[k].be, vec[k].wd, 1'b0);
      exp_v = vec[k].w ? WT : 1'b1;
      chk1("tbl_rv", ReadValid, exp_v);
      if (exp_v) chk32("tbl_rd", ReadData, vec[k].exp);
    end

    // Clear with a write pending: not accepted, 16 busy cycles, Clear during CLEAR ignored.
    cycle(1'b1, 1'b1, 4'd5, 4'hF, 32'hFFFFFFFF, 1'b1);
    for (int k = 0; k < 16; k++)
      cycle(1'b1, k[0], 4'd5, 4'hF, 32'h5A5A5A5A, (k == 8));
    cycle(1'b1, 1'b0, 4'd5, 4'h0, 32'h0, 1'b0);
    chk32("addr5_after_clear", ReadData, 32'h0);

    // Reset during cycle 7 of a clear restarts a full clear.
    cycle(1'b1, 1'b1, 4'd2, 4'hF, 32'hCAFEF00D, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0);
    apply_reset();
    for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 1'b0);
    chk32("addr2_after_reclear", ReadData, 32'h0);

    // Random traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      ra  = 4'($urandom);
      rbe = 4'($urandom);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), ra, rbe, $urandom,
            $urandom_range(0, 49) == 0);
    end
    while (clear_left > 0) cycle(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0);

    // Reset with a read about to be captured drops it.
    cycle(1'b1, 1'b1, 4'd6, 4'hF, 32'h87654321, 1'b0);
    ReqValid = 1'b1; MemWrite = 1'b0; Address = 4'd6; Clear = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    chk1("inflight_rv_in_reset", ReadValid, 1'b0);
    @(posedge Clock); #1;
    chk1("inflight_rv_dropped", ReadValid, 1'b0);
    chk32("inflight_rd_zero", ReadData, 32'h0);
    chk1("inflight_busy", Busy, 1'b1);
    Reset = 1'b0; ReqValid = 1'b0;
    clear_left = 16; exp_rv = 1'b0; exp_rd = 32'h0;
    zero_model();
    for (int k = 0; k < 17; k++) cycle(1'b1, 1'b0, 4'd6, 4'h0, 32'h0, 1'b0);
    chk32("addr6_after_reset_clear", ReadData, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
